// File: rtl/cmp_pkg.sv
// cmp_pkg: shared FSM state encoding, result struct and digit-count helper for seq_magnitude_comparator
package cmp_pkg;

    typedef logic [1:0] cmp_state_t;

    localparam cmp_state_t IDLE = 2'd0;
    localparam cmp_state_t SCAN = 2'd1;
    localparam cmp_state_t DONE = 2'd2;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_res_t;

    function automatic int cmp_ndig(input int width, input int digit_w);
        return width / digit_w;
    endfunction

endpackage

// File: rtl/cmp_digit_unit.sv
// cmp_digit_unit: combinational unsigned compare of one digit, optionally inverting the MSBs (signed top digit)
module cmp_digit_unit #(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] da,
    input  logic [DIGIT_W-1:0] db,
    input  logic               flip_msb,
    output logic               gt,
    output logic               lt
);

    localparam logic [DIGIT_W-1:0] MSB = {1'b1, {(DIGIT_W-1){1'b0}}};

    logic [DIGIT_W-1:0] fa, fb;

    assign fa = flip_msb ? da ^ MSB : da;
    assign fb = flip_msb ? db ^ MSB : db;
    assign gt = fa > fb;
    assign lt = fa < fb;

endmodule

// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: MSB-first digit-serial signed/unsigned comparator with early exit; CMP_MINMAX_EN adds min/max outputs
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int DIGIT_W = 4,
    localparam int NDIG    = cmp_ndig(WIDTH, DIGIT_W),
    localparam int IW      = (NDIG > 1) ? $clog2(NDIG) : 1,
    localparam int CW      = $clog2(NDIG + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef CMP_MINMAX_EN
    output logic [WIDTH-1:0] min_val,
    output logic [WIDTH-1:0] max_val,
`endif
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic [CW-1:0]    cycles
);

    if (WIDTH < 2 || WIDTH % DIGIT_W != 0) begin : g_bad_params
        $error("seq_magnitude_comparator: WIDTH must be >= 2 and a multiple of DIGIT_W");
    end

    cmp_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sm_q, sm_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d, cycles_q, cycles_d;
    cmp_res_t         res_q, res_d;
`ifdef CMP_MINMAX_EN
    logic [WIDTH-1:0] min_q, min_d, max_q, max_d;
`endif

    logic dgt, dlt;

    cmp_digit_unit #(.DIGIT_W(DIGIT_W)) u_digit (
        .da       (a_q[idx_q*DIGIT_W +: DIGIT_W]),
        .db       (b_q[idx_q*DIGIT_W +: DIGIT_W]),
        .flip_msb (sm_q && idx_q == IW'(NDIG - 1)),
        .gt       (dgt),
        .lt       (dlt)
    );

    // next-state: accept in IDLE, scan one digit per cycle, hold result until consumed
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sm_d     = sm_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        cycles_d = cycles_q;
`ifdef CMP_MINMAX_EN
        min_d    = min_q;
        max_d    = max_q;
`endif
        if (state_q == IDLE) begin
            if (in_valid) begin
                a_d     = a;
                b_d     = b;
                sm_d    = signed_mode;
                idx_d   = IW'(NDIG - 1);
                cnt_d   = '0;
                state_d = SCAN;
            end
        end else if (state_q == SCAN) begin
            if (dgt || dlt || idx_q == '0) begin
                res_d    = '{gt: dgt, lt: dlt, eq: !(dgt || dlt)};
                cycles_d = (dgt || dlt) ? cnt_q + CW'(1) : CW'(NDIG);
`ifdef CMP_MINMAX_EN
                min_d    = dgt ? b_q : a_q;
                max_d    = dlt ? b_q : a_q;
`endif
                state_d  = DONE;
            end else begin
                idx_d = idx_q - IW'(1);
                cnt_d = cnt_q + CW'(1);
            end
        end else if (out_ready) begin
            res_d    = '0;
            cycles_d = '0;
`ifdef CMP_MINMAX_EN
            min_d    = '0;
            max_d    = '0;
`endif
            state_d  = IDLE;
        end
    end

    // state and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sm_q     <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            cycles_q <= '0;
`ifdef CMP_MINMAX_EN
            min_q    <= '0;
            max_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sm_q     <= sm_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            cycles_q <= cycles_d;
`ifdef CMP_MINMAX_EN
            min_q    <= min_d;
            max_q    <= max_d;
`endif
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign gt        = res_q.gt;
    assign lt        = res_q.lt;
    assign eq        = res_q.eq;
    assign cycles    = cycles_q;
`ifdef CMP_MINMAX_EN
    assign min_val   = min_q;
    assign max_val   = max_q;
`endif

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit GT/LT/EQ comparator.
- Compares two WIDTH-bit operands in signed or unsigned mode, scanning DIGIT_W bits per cycle from the MSB, with early termination on the first unequal digit.
- Uses valid/ready handshakes on both sides, so it can sit between datapath stages that run sort, min/max and branch-condition logic.

Parameters:
- WIDTH, 16: operand width in bits; must be ≥ 2.
- DIGIT_W, 4: bits compared per cycle; WIDTH % DIGIT_W == 0 is required, checked by elaboration-time assertion.
- NDIG, WIDTH/DIGIT_W: derived digit count; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept; equals (state == IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned.
- out_valid  out  1  result available; equals (state == DONE).
- out_ready  in  1  consumer accepts the result.
- gt  out  1  A > B.
- lt  out  1  A < B.
- eq  out  1  A == B.
- cycles  out  $clog2(NDIG+1)  number of digits scanned, range 1..NDIG.

Behaviour:
- Reset:
  - One clock and a synchronous active-high reset: `clk` and `rst`, sampled on the rising edge of `clk`.
  - rst=1 at an edge forces state IDLE, clears internal regs, and sets gt/lt/eq/cycles = 0.
  - Consequently out_valid=0 and in_ready=1 in the cycle after that edge.
  - Reset mid-SCAN or mid-DONE aborts the operation; no result is ever presented for it.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_valid && in_ready at edge T latches a, b and signed_mode, sets digit index idx = NDIG-1 and cnt = 0, and moves to SCAN.
  - Changes on a/b after T are ignored.
- SCAN:
  - Each cycle compares digit idx of A and B.
  - For the top digit in signed mode, the operand MSBs are inverted before an unsigned compare (sign-flip trick).
  - If the digits differ: set gt or lt, set cycles = cnt+1, go to DONE.
  - If the digits are equal and idx == 0: set eq=1, set cycles = NDIG, go to DONE.
  - Otherwise: idx--, cnt++.
- Latency: with k digits scanned, out_valid is high from edge T+k. Minimum is 1 cycle; maximum is NDIG.
- DONE:
  - out_valid=1, and gt/lt/eq/cycles are held stable until out_valid && out_ready at an edge.
  - That edge returns to IDLE and clears gt/lt/eq/cycles to 0.
  - No bypass: at least one IDLE cycle separates operations.
  - in_valid is ignored outside IDLE.
- Output rules:
  - Exactly one of gt/lt/eq is 1 while out_valid is high; all are 0 otherwise.
  - All outputs are registered; in_ready and out_valid decode directly from the state register.
- Width rules:
  - idx is $clog2(NDIG) bits, with no wrap-around: the scan stops at idx == 0.
  - With NDIG == 1, the single digit is also the top digit and gets the sign flip.

Optional Feature:
- Macro: CMP_MINMAX_EN.
- When defined:
  - Adds ports min_val out WIDTH and max_val out WIDTH.
  - Both are registered in the same edge as the result and selected from the latched operands, honouring signed_mode.
  - On eq, min_val = max_val = A.
  - Both are 0 outside DONE.
- When undefined: the ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Package cmp_pkg holds:
  - Typedef cmp_state_t (IDLE, SCAN, DONE).
  - Constant function cmp_ndig(width, digit_w).
  - Typedef cmp_res_t, a packed struct {gt, lt, eq}.
- Sub-module cmp_digit_unit:
  - Purely combinational, parameter DIGIT_W.
  - Inputs: two digits and flip_msb.
  - Outputs: gt and lt.
  - Instantiated once and fed by a mux on idx.

Test Plan:
- WIDTH=16, DIGIT_W=4, unsigned, A=0x1234, B=0x1234 accepted at T -> out_valid at T+4, eq=1, cycles=4.
- A=0x9000, B=0x1000: unsigned -> gt=1, cycles=1; signed -> lt=1, cycles=1. Both results appear at T+1.
- Signed A=0xFFFF, B=0x0001 -> lt=1, cycles=1; with CMP_MINMAX_EN, min_val=0xFFFF and max_val=0x0001.
- Unsigned A=0x00F1, B=0x00F0 -> gt=1, cycles=4.
- Back-pressure with out_ready=0 for 5 cycles:
  - out_valid, gt and cycles stay stable; in_ready stays 0.
  - in_valid pulses with new operands are ignored.
  - After out_ready=1, one IDLE cycle follows, then the next accept is possible.
- rst=1 on the 2nd SCAN cycle of an equal-operand compare -> next cycle IDLE, out_valid=0, in_ready=1, outputs 0, no result emitted.
